// File: rtl/seq_arith_unit_if.sv
// Request/response bundle between the control unit and the sequential arithmetic unit.
interface seq_arith_unit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] remainder;
    logic             carry;
    logic             borrow;
    logic             overflow;
    logic             zero;
    logic             dbz;
    logic             err;

    modport master (
        output start, op, a, b,
        input  ready, done, result, remainder, carry, borrow, overflow, zero, dbz, err
    );
    modport slave (
        input  start, op, a, b,
        output ready, done, result, remainder, carry, borrow, overflow, zero, dbz, err
    );
endinterface

// File: rtl/seq_arith_unit.sv
// Unsigned ADD/SUB (single cycle) and restoring DIV (one step per cycle) behind start/done.
module seq_arith_unit #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    seq_arith_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [1:0] OP_ADD = 2'b00, OP_SUB = 2'b01, OP_DIV = 2'b10;

    typedef enum logic {IDLE, DIV_RUN} state_t;

    state_t           state_q;
    logic [WIDTH:0]   p_q;
    logic [WIDTH-1:0] q_q, d_q;
    logic [CW-1:0]    cnt_q;
    logic             ready_q, done_q;
    logic [WIDTH-1:0] res_q, rem_q;
    logic             carry_q, borrow_q, ovf_q, zero_q, dbz_q, err_q;

    logic [WIDTH:0]   sum, diff, p_sh, t, p_d;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        sum  = {1'b0, bus.a} + {1'b0, bus.b};
        diff = {1'b0, bus.a} - {1'b0, bus.b};
        // P < D always holds between steps, so the shifted value fits in WIDTH+1 bits
        p_sh = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        t    = p_sh - {1'b0, d_q};
        p_d  = p_sh;
        q_d  = {q_q[WIDTH-2:0], 1'b0};
        if (!t[WIDTH]) begin
            p_d    = t;
            q_d[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            p_q      <= '0;
            q_q      <= '0;
            d_q      <= '0;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            res_q    <= '0;
            rem_q    <= '0;
            carry_q  <= 1'b0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    if (bus.op == OP_DIV && bus.b != '0) begin
                        q_q     <= bus.a;
                        p_q     <= '0;
                        d_q     <= bus.b;
                        cnt_q   <= CW'(WIDTH);
                        ready_q <= 1'b0;
                        state_q <= DIV_RUN;
                    end else begin
                        // every single-cycle completion rewrites all outputs
                        done_q   <= 1'b1;
                        res_q    <= '0;
                        rem_q    <= '0;
                        carry_q  <= 1'b0;
                        borrow_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= 1'b1;
                        dbz_q    <= 1'b0;
                        err_q    <= 1'b0;
                        case (bus.op)
                            OP_ADD: begin
                                res_q   <= sum[WIDTH-1:0];
                                carry_q <= sum[WIDTH];
                                ovf_q   <= (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                                           (sum[WIDTH-1] != bus.a[WIDTH-1]);
                                zero_q  <= (sum[WIDTH-1:0] == '0);
                            end
                            OP_SUB: begin
                                res_q    <= diff[WIDTH-1:0];
                                borrow_q <= diff[WIDTH];
                                ovf_q    <= (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                                            (diff[WIDTH-1] != bus.a[WIDTH-1]);
                                zero_q   <= (diff[WIDTH-1:0] == '0);
                            end
                            OP_DIV: begin
                                res_q  <= '1;
                                rem_q  <= bus.a;
                                dbz_q  <= 1'b1;
                                zero_q <= 1'b0;
                            end
                            default: err_q <= 1'b1;
                        endcase
                    end
                end
                DIV_RUN: begin
                    p_q   <= p_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        done_q   <= 1'b1;
                        res_q    <= q_d;
                        rem_q    <= p_d[WIDTH-1:0];
                        carry_q  <= 1'b0;
                        borrow_q <= 1'b0;
                        ovf_q    <= 1'b0;
                        zero_q   <= (q_d == '0);
                        dbz_q    <= 1'b0;
                        err_q    <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.result    = res_q;
    assign bus.remainder = rem_q;
    assign bus.carry     = carry_q;
    assign bus.borrow    = borrow_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
    assign bus.dbz       = dbz_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_seq_arith_unit.sv
// Directed checks of the 8-bit unit plus randomised sweeps at WIDTH=4 and WIDTH=16.
module tb_seq_arith_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seq_arith_unit_if #(.WIDTH(8))  i8 ();
    seq_arith_unit_if #(.WIDTH(4))  i4 ();
    seq_arith_unit_if #(.WIDTH(16)) i16 ();

    seq_arith_unit #(.WIDTH(8))  u8  (.clk(clk), .rst(rst), .bus(i8));
    seq_arith_unit #(.WIDTH(4))  u4  (.clk(clk), .rst(rst), .bus(i4));
    seq_arith_unit #(.WIDTH(16)) u16 (.clk(clk), .rst(rst), .bus(i16));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // flags packed as {carry, borrow, overflow, zero, dbz, err}
    function automatic logic [5:0] fl8();
        return {i8.carry, i8.borrow, i8.overflow, i8.zero, i8.dbz, i8.err};
    endfunction

    task automatic run8(input logic [1:0] o, input logic [7:0] x, input logic [7:0] y,
                        output int lat, output int rlow);
        @(negedge clk);
        i8.start = 1'b1; i8.op = o; i8.a = x; i8.b = y;
        @(posedge clk); #1;
        i8.start = 1'b0; i8.a = ~x; i8.b = ~y;
        lat = 1; rlow = 0;
        while (!i8.done && lat < 40) begin
            if (!i8.ready) rlow++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Reference: {latency[7:0], result[15:0], remainder[15:0], 2'b0, flags[5:0]}
    function automatic logic [47:0] model(input int w, input logic [1:0] o,
                                          input logic [15:0] x, input logic [15:0] y);
        int s, mask, lat;
        logic [15:0] r, m;
        logic c, bo, ov, dz, er;
        mask = (1 << w) - 1;
        r = '0; m = '0; c = 0; bo = 0; ov = 0; dz = 0; er = 0; lat = 1;
        case (o)
            2'b00: begin
                s = int'(x) + int'(y);
                r = 16'(s & mask);
                c = ((s >> w) & 1) != 0;
                ov = (x[w-1] == y[w-1]) && (r[w-1] != x[w-1]);
            end
            2'b01: begin
                s = int'(x) - int'(y);
                r = 16'(s & mask);
                bo = x < y;
                ov = (x[w-1] != y[w-1]) && (r[w-1] != x[w-1]);
            end
            2'b10: begin
                if (y == 0) begin
                    r = 16'(mask); m = x; dz = 1;
                end else begin
                    r = x / y; m = x % y; lat = w + 1;
                end
            end
            default: er = 1;
        endcase
        return {8'(lat), r, m, 2'b00, c, bo, ov, (r == 0), dz, er};
    endfunction

    task automatic sweep4(input int n);
        logic [1:0] o; logic [3:0] x, y; int lat;
        for (int k = 0; k < n; k++) begin
            o = 2'($urandom_range(0, 3));
            x = 4'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
            @(negedge clk);
            i4.start = 1'b1; i4.op = o; i4.a = x; i4.b = y;
            @(posedge clk); #1;
            i4.start = 1'b0; i4.a = ~x; i4.b = ~y;
            lat = 1;
            while (!i4.done && lat < 40) begin @(posedge clk); #1; lat++; end
            chk("sweep4", {8'(lat), 12'd0, i4.result, 12'd0, i4.remainder, 2'b00,
                 i4.carry, i4.borrow, i4.overflow, i4.zero, i4.dbz, i4.err},
                {16'd0, model(4, o, {12'd0, x}, {12'd0, y})});
        end
    endtask

    task automatic sweep16(input int n);
        logic [1:0] o; logic [15:0] x, y; int lat;
        for (int k = 0; k < n; k++) begin
            o = 2'($urandom_range(0, 3));
            x = 16'($urandom);
            y = ($urandom_range(0, 5) == 0) ? 16'd0 :
                ($urandom_range(0, 1) == 0) ? 16'($urandom_range(1, 300)) : 16'($urandom);
            @(negedge clk);
            i16.start = 1'b1; i16.op = o; i16.a = x; i16.b = y;
            @(posedge clk); #1;
            i16.start = 1'b0; i16.a = ~x; i16.b = ~y;
            lat = 1;
            while (!i16.done && lat < 40) begin @(posedge clk); #1; lat++; end
            chk("sweep16", {8'(lat), i16.result, i16.remainder, 2'b00,
                 i16.carry, i16.borrow, i16.overflow, i16.zero, i16.dbz, i16.err},
                {16'd0, model(16, o, x, y)});
        end
    endtask

    initial begin
        int lat, rlow, dcnt;
        i8.start = 0;  i8.op = 0;  i8.a = 0;  i8.b = 0;
        i4.start = 0;  i4.op = 0;  i4.a = 0;  i4.b = 0;
        i16.start = 0; i16.op = 0; i16.a = 0; i16.b = 0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", i8.ready, 1);
        chk("rst_done", i8.done, 0);
        chk("rst_result", i8.result, 0);
        chk("rst_rem", i8.remainder, 0);
        chk("rst_flags", fl8(), 0);
        @(negedge clk); rst = 1'b1;

        run8(2'b00, 8'd200, 8'd100, lat, rlow);
        chk("add_lat", lat, 1);
        chk("add_res", i8.result, 44);
        chk("add_flags", fl8(), 6'b100000);
        chk("add_ready", i8.ready, 1);

        run8(2'b01, 8'd5, 8'd7, lat, rlow);
        chk("sub1_res", i8.result, 254);
        chk("sub1_flags", fl8(), 6'b010000);

        run8(2'b01, 8'h80, 8'h01, lat, rlow);
        chk("sub2_res", i8.result, 8'h7F);
        chk("sub2_flags", fl8(), 6'b001000);

        run8(2'b00, 8'h80, 8'h80, lat, rlow);
        chk("add0_res", i8.result, 0);
        chk("add0_flags", fl8(), 6'b101100);

        run8(2'b10, 8'd100, 8'd7, lat, rlow);
        chk("div1_lat", lat, 9);
        chk("div1_rlow", rlow, 8);
        chk("div1_res", {i8.result, i8.remainder}, {8'd14, 8'd2});
        chk("div1_flags", fl8(), 0);
        @(posedge clk); #1;
        chk("div1_done_pulse", i8.done, 0);

        run8(2'b10, 8'd255, 8'd255, lat, rlow);
        chk("div2_res", {i8.result, i8.remainder}, {8'd1, 8'd0});
        chk("div2_lat", lat, 9);

        run8(2'b10, 8'd37, 8'd0, lat, rlow);
        chk("dbz_lat", lat, 1);
        chk("dbz_res", {i8.result, i8.remainder}, {8'd255, 8'd37});
        chk("dbz_flags", fl8(), 6'b000010);

        run8(2'b00, 8'd1, 8'd1, lat, rlow);
        chk("add11_res", {i8.result, i8.remainder}, {8'd2, 8'd0});
        chk("add11_flags", fl8(), 0);

        // start pulses while busy must be dropped
        @(negedge clk);
        i8.start = 1; i8.op = 2'b10; i8.a = 8'd200; i8.b = 8'd3;
        @(posedge clk); #1;
        i8.op = 2'b00; i8.a = 8'd1; i8.b = 8'd1;
        repeat (3) @(posedge clk);
        #1; i8.start = 0;
        lat = 4; dcnt = 0;
        while (!i8.done && lat < 40) begin
            if (i8.done) dcnt++;
            @(posedge clk); #1; lat++;
        end
        chk("busy_lat", lat, 9);
        chk("busy_res", {i8.result, i8.remainder}, {8'd66, 8'd2});
        @(posedge clk); #1;
        chk("busy_no_extra", i8.done, 0);

        // reset during the 4th DIV step
        @(negedge clk);
        i8.start = 1; i8.op = 2'b10; i8.a = 8'd250; i8.b = 8'd9;
        @(posedge clk); #1; i8.start = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); rst = 0;
        @(posedge clk); #1; rst = 1;
        chk("abort_ready", i8.ready, 1);
        chk("abort_done", i8.done, 0);
        chk("abort_out", {i8.result, i8.remainder, 2'b00, fl8()}, 0);
        dcnt = 0;
        repeat (12) begin @(posedge clk); #1; if (i8.done) dcnt++; end
        chk("abort_no_done", dcnt, 0);

        run8(2'b11, 8'd9, 8'd4, lat, rlow);
        chk("err_lat", lat, 1);
        chk("err_res", {i8.result, i8.remainder}, 0);
        chk("err_flags", fl8(), 6'b000101);

        // back-to-back ADDs complete on consecutive cycles
        @(negedge clk);
        i8.start = 1; i8.op = 2'b00; i8.a = 8'd3; i8.b = 8'd4;
        @(posedge clk); #1;
        i8.a = 8'd10; i8.b = 8'd20;
        chk("b2b_1", {i8.done, i8.result}, {1'b1, 8'd7});
        @(posedge clk); #1;
        i8.start = 0;
        chk("b2b_2", {i8.done, i8.result}, {1'b1, 8'd30});
        @(posedge clk); #1;
        chk("b2b_end", i8.done, 0);

        sweep4(1000);
        sweep16(1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/seq_arith_unit.md
# seq_arith_unit

Parametrised, clocked arithmetic unit. It performs ADD, SUB and restoring DIV on unsigned WIDTH-bit operands behind a start/done handshake. ADD and SUB complete in a single cycle. DIV runs one restoring step per cycle, with divide-by-zero detection, a remainder output and registered status flags. It replaces the combinational 8-bit arithmetic unit in the datapath: the control unit drives `op` and `start`, and the register file captures `result` on `done`.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits; legal range is 2 or more.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  in  1  request; sampled only when ready=1.
- op  in  2  operation: 00 ADD, 01 SUB, 10 DIV, 11 reserved.
- a  in  WIDTH  operand A (minuend or dividend).
- b  in  WIDTH  operand B (subtrahend or divisor).
- ready  out  1  high in IDLE; unit accepts start.
- done  out  1  one-cycle pulse; outputs below are valid from this cycle on.
- result  out  WIDTH  sum, difference or quotient.
- remainder  out  WIDTH  DIV remainder; 0 for other ops.
- carry  out  1  ADD carry-out.
- borrow  out  1  SUB borrow (a < b unsigned).
- overflow  out  1  ADD/SUB two's-complement overflow.
- zero  out  1  result == 0.
- dbz  out  1  DIV with b == 0.
- err  out  1  op == 11.

## Operation
- States: IDLE, DIV_RUN.
- Operands are captured at the accepting edge; a and b may change afterwards.
- IDLE with start=1 and op=ADD:
  - result = (a+b) mod 2^WIDTH; carry = bit WIDTH of the sum.
  - overflow = a[MSB]==b[MSB] and result[MSB]!=a[MSB].
  - done is set; state stays IDLE.
- op=SUB:
  - result = (a−b) mod 2^WIDTH; borrow = (a<b).
  - overflow = a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
  - done is set.
- op=DIV with b==0: result = all ones, remainder = a, dbz=1, done is set, no iterations.
- op=DIV with b!=0: load Q=a, P=0 (WIDTH+1 bits), D=b, count=WIDTH; go to DIV_RUN.
- Each DIV_RUN cycle performs one restoring step:
  - Shift {P,Q} left 1.
  - T = P−D; if T is non-negative, P=T and Q[0]=1; else restore P and Q[0]=0.
  - count decrements.
- At the step where count reaches 0: result=Q, remainder=P[WIDTH−1:0], done is set, return to IDLE.
- op=11: result=0, remainder=0, err=1, done is set.
- Each completion clears every flag that does not apply to its op. zero always equals (result==0).
- result, remainder and flags hold their values until the next completion.
- start while ready=0 is ignored; it is not queued.
- Reset (rst=0 at an edge) aborts any operation, returns to IDLE, and zeroes all outputs except ready.

## Timing
- Reset values: ready=1, done=0, result=0, remainder=0, all flags 0, state IDLE, count=0.
- ADD/SUB/err/dbz: start accepted at edge E0 → done=1 in the cycle after E0. Latency 1; ready stays 1.
- DIV with b!=0:
  - start at E0; steps at edges E1..E_WIDTH.
  - done=1 in the cycle after E_WIDTH. Latency WIDTH+1 edges.
  - ready=0 from after E0 until after E_WIDTH.
- done is high exactly one cycle per accepted start.
- Back-to-back operation is legal. A start sampled in the done cycle, when ready=1, is accepted, so one op can complete per cycle for ADD/SUB.
- rst=0 takes priority over start at the same edge. rst=0 during DIV_RUN produces no done.

## Test plan
- WIDTH=8, ADD a=200 b=100 → done 1 cycle later; result=44, carry=1, overflow=0, zero=0.
- SUB:
  - a=5 b=7 → result=254, borrow=1, overflow=0.
  - a=0x80 b=0x01 → result=0x7F, overflow=1, borrow=0.
- DIV a=100 b=7 → ready low for 8 cycles; done exactly on the 9th edge after start; result=14, remainder=2. Then run a=255 b=255 → 1 r 0.
- DIV by zero, a=37 b=0 → done after 1 cycle; result=255, remainder=37, dbz=1. The next ADD 1+1 clears dbz and gives result=2.
- Control and error cases:
  - start pulses during DIV_RUN → ignored; DIV result unaffected.
  - rst=0 on the 4th DIV cycle → next cycle ready=1, done=0, all outputs 0; no done follows.
  - op=11 → err=1, result=0.
- Parameter sweep WIDTH=4 and WIDTH=16: randomised 1000 ops per width checked against a reference model, including the b=0 case.
